// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory controller.
//   - access size encodings carried on req_size
//   - controller FSM state type
//   - byte-lane count of one RAM word
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 32-bit RAM word.
// Ports:
//   size      access size (SZ_B / SZ_H / SZ_W, 3 = illegal)
//   lane      byte offset within the word (addr[1:0])
//   zext      zero-extend loads when 1, sign-extend when 0
//   wdata     right-aligned store data
//   rword     raw RAM word being read
//   be        byte-enable mask of the lanes touched by the access
//   misalign  half on an odd address or word on a non-zero offset
//   wlanes    store data replicated so every enabled lane sees its byte
//   rdata     extracted and extended load data
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       lane,
  input  logic             zext,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic             misalign,
  output logic [31:0]      wlanes,
  output logic [31:0]      rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be       = '0;
    misalign = 1'b0;
    wlanes   = wdata;
    rdata    = '0;
    ld_byte  = rword[8*lane +: 8];
    ld_half  = rword[16*lane[1] +: 16];
    case (size)
      SZ_B: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata[7:0]}};
        rdata  = zext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        misalign = lane[0];
        be       = 4'b0011 << lane;
        wlanes   = {2{wdata[15:0]}};
        rdata    = zext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SZ_W: begin
        misalign = |lane;
        be       = 4'b1111;
        rdata    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed, word-organised data RAM behind a valid/ready
// request channel with a one-cycle pulsed response. One access in flight.
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity + par_inject).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_size           0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned       zero-extend loads when 1
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   par_inject         (DMEM_PARITY_EN only) flip stored parity of written lanes
//   rsp_valid          one-cycle response pulse
//   rsp_rdata          extended load data, 0 for stores and errors
//   rsp_err            misaligned / illegal / out-of-range (or parity) error
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic              par_inject,
`endif
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W      = $clog2(DEPTH);
  localparam logic [3:0]      LAT_LAST   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);

  state_t            state;
  logic [3:0]        cnt;

  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_uns;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic [31:0]       mem [DEPTH];

  // With LATENCY=0 the commit edge is the handshake edge itself, so the
  // access is evaluated on the live request while idle and on the captured
  // copy otherwise.
  logic              in_idle;
  logic              hs;
  logic              commit;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rword;
  logic [LANES-1:0]  be;
  logic              misalign;
  logic [31:0]       wlanes;
  logic [31:0]       ld_data;
  logic              oor;
  logic              acc_err;
  logic              par_err;

  assign in_idle   = (state == S_IDLE);
  assign req_ready = in_idle && !reset;
  assign hs        = req_valid && req_ready;
  assign commit    = (in_idle && hs && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == LAT_LAST));

  assign cur_we    = in_idle ? req_we       : cap_we;
  assign cur_size  = in_idle ? req_size     : cap_size;
  assign cur_uns   = in_idle ? req_unsigned : cap_uns;
  assign cur_addr  = in_idle ? req_addr     : cap_addr;
  assign cur_wdata = in_idle ? req_wdata    : cap_wdata;

  assign idx     = cur_addr[IDX_W+1:2];
  assign rword   = mem[idx];
  assign oor     = ({1'b0, cur_addr} >= ADDR_LIMIT);
  assign acc_err = misalign || (cur_size == 2'd3) || oor;

  dmem_lane_align u_align (
    .size     (cur_size),
    .lane     (cur_addr[1:0]),
    .zext     (cur_uns),
    .wdata    (cur_wdata),
    .rword    (rword),
    .be       (be),
    .misalign (misalign),
    .wlanes   (wlanes),
    .rdata    (ld_data)
  );

  // NOTE: the RAM has no reset; only the gated write enable keeps aborted accesses out.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_we && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic             cap_inj;
  logic             cur_inj;
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wpar;
  logic [LANES-1:0] rpar;

  assign cur_inj = in_idle ? par_inject : cap_inj;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wpar[i] = (^wlanes[8*i +: 8]) ^ cur_inj;
      rpar[i] = ^rword[8*i +: 8];
    end
  end

  // Only the lanes actually read take part in the check.
  assign par_err = !cur_we && |(be & (par_mem[idx] ^ rpar));

  always_ff @(posedge clk) begin
    if (hs) cap_inj <= par_inject;
    if (!reset && commit && cur_we && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) par_mem[idx][i] <= wpar[i];
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= '0;
            state     <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == LAT_LAST) state <= S_RESP;
          else                 cnt   <= cnt + 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err || (!acc_err && par_err);
        rsp_rdata <= (acc_err || cur_we) ? 32'h0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl. Two instances share the
// clock and reset: dut_a with LATENCY=1 for single accesses and reset abort,
// dut_b with LATENCY=0 for back-to-back throughput. A byte-array model of
// each RAM produces expected responses that are queued at the handshake and
// popped when the DUT pulses rsp_valid.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              valid_a, ready_a, we_a, uns_a, rsp_valid_a, rsp_err_a;
  logic [1:0]        size_a;
  logic [ADDR_W-1:0] addr_a;
  logic [31:0]       wdata_a, rsp_rdata_a;
  logic              valid_b, ready_b, we_b, uns_b, rsp_valid_b, rsp_err_b;
  logic [1:0]        size_b;
  logic [ADDR_W-1:0] addr_b;
  logic [31:0]       wdata_b, rsp_rdata_b;

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(ready_a),
    .req_we(we_a), .req_size(size_a), .req_unsigned(uns_a), .req_addr(addr_a),
    .req_wdata(wdata_a),
`ifdef DMEM_PARITY_EN
    .par_inject(1'b0),
`endif
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(ready_b),
    .req_we(we_b), .req_size(size_b), .req_unsigned(uns_b), .req_addr(addr_b),
    .req_wdata(wdata_b),
`ifdef DMEM_PARITY_EN
    .par_inject(1'b0),
`endif
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  exp_t       e_a, e_b;
  logic [7:0] mm_a [4*DEPTH];
  logic [7:0] mm_b [4*DEPTH];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mrd(input bit sel, input int a);
    return sel ? mm_b[a] : mm_a[a];
  endfunction

  // Reference behaviour: error rules, lane writes and load extension.
  task automatic model(input bit sel, input req_t r, output logic [31:0] rd, output logic err);
    int         a;
    int         nb;
    logic [7:0] b;
    logic [15:0] h;
    err = (r.size == 2'd3) || (r.size == SZ_H && r.addr[0]) ||
          (r.size == SZ_W && r.addr[1:0] != 2'b00) || (r.addr >= 32'(4*DEPTH));
    rd = 32'h0;
    if (!err) begin
      a = int'(r.addr);
      if (r.we) begin
        nb = (r.size == SZ_B) ? 1 : (r.size == SZ_H) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          if (sel) mm_b[a+k] = r.wdata[8*k +: 8];
          else     mm_a[a+k] = r.wdata[8*k +: 8];
        end
      end else begin
        case (r.size)
          SZ_B: begin
            b  = mrd(sel, a);
            rd = r.uns ? {24'h0, b} : {{24{b[7]}}, b};
          end
          SZ_H: begin
            h  = {mrd(sel, a+1), mrd(sel, a)};
            rd = r.uns ? {16'h0, h} : {{16{h[15]}}, h};
          end
          default: rd = {mrd(sel, a+3), mrd(sel, a+2), mrd(sel, a+1), mrd(sel, a)};
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid_a) begin
      if (q_a.size() == 0) check("a_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e_a = q_a.pop_front();
        check("a_rdata", rsp_rdata_a, e_a.rdata);
        check("a_err", {31'h0, rsp_err_a}, {31'h0, e_a.err});
        check("a_latency", cyc - e_a.t, LAT_A + 1);
      end
    end
    if (!reset && rsp_valid_b) begin
      if (q_b.size() == 0) check("b_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e_b = q_b.pop_front();
        check("b_rdata", rsp_rdata_b, e_b.rdata);
        check("b_err", {31'h0, rsp_err_b}, {31'h0, e_b.err});
        check("b_latency", cyc - e_b.t, LAT_B + 1);
      end
    end
  end

  task automatic drive_a(input req_t r);
    valid_a = 1'b1;
    we_a    = r.we;
    size_a  = r.size;
    uns_a   = r.uns;
    addr_a  = r.addr;
    wdata_a = r.wdata;
  endtask

  // Single access on dut_a; called and returns at a negedge.
  task automatic req_a(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_t        r;
    logic [31:0] rd;
    logic        er;
    int          k;
    r = '{we: we, size: sz, uns: uns, addr: addr, wdata: wd};
    drive_a(r);
    k = 0;
    while (!ready_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready_a) begin
      check("a_ready_timeout", 32'd0, 32'd1);
      valid_a = 1'b0;
      return;
    end
    model(1'b0, r, rd, er);
    q_a.push_back('{rdata: rd, err: er, t: cyc});
    @(negedge clk);
    check("a_ready_busy", {31'h0, ready_a}, 32'd0);
    valid_a = 1'b0;
    k = 0;
    while (q_a.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (q_a.size() != 0) check("a_rsp_timeout", q_a.size(), 32'd0);
  endtask

  req_t        b_seq [5];
  logic [31:0] rd_b;
  logic        er_b;
  int          last_hs;
  int          wt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {valid_a, we_a, uns_a, size_a, addr_a, wdata_a} = '0;
    {valid_b, we_b, uns_b, size_b, addr_b, wdata_b} = '0;
    for (int i = 0; i < 4*DEPTH; i++) begin
      mm_a[i] = 8'h0;
      mm_b[i] = 8'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready_a", {31'h0, ready_a}, 32'd0);
    check("rst_valid_a", {31'h0, rsp_valid_a}, 32'd0);
    check("rst_rdata_a", rsp_rdata_a, 32'd0);
    check("rst_err_a", {31'h0, rsp_err_a}, 32'd0);
    check("rst_ready_b", {31'h0, ready_b}, 32'd0);
    check("rst_valid_b", {31'h0, rsp_valid_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_a", {31'h0, ready_a}, 32'd1);
    check("idle_ready_b", {31'h0, ready_b}, 32'd1);

    // Basic word, byte and half accesses.
    req_a(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF);
    req_a(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    req_a(1'b0, SZ_B, 1'b0, 32'h13, 32'h0);
    req_a(1'b0, SZ_B, 1'b1, 32'h13, 32'h0);
    req_a(1'b0, SZ_H, 1'b0, 32'h12, 32'h0);
    req_a(1'b0, SZ_H, 1'b1, 32'h12, 32'h0);
    req_a(1'b0, SZ_B, 1'b0, 32'h10, 32'h0);
    req_a(1'b0, SZ_W, 1'b1, 32'h10, 32'h0);
    // Byte store into one lane, then a misaligned half store that must not write.
    req_a(1'b1, SZ_B, 1'b0, 32'h11, 32'hFFFFFF55);
    req_a(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    req_a(1'b1, SZ_H, 1'b0, 32'h11, 32'h00001234);
    req_a(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    // Error cases: range, illegal size, misaligned word load.
    req_a(1'b0, SZ_W, 1'b0, 32'(4*DEPTH), 32'h0);
    req_a(1'b0, SZ_W, 1'b0, 32'hFFFFFFF0, 32'h0);
    req_a(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    req_a(1'b1, 2'd3, 1'b0, 32'h14, 32'hA5A5A5A5);
    req_a(1'b0, SZ_W, 1'b0, 32'h12, 32'h0);
    // Last word of the array is still in range.
    req_a(1'b1, SZ_W, 1'b0, 32'(4*DEPTH-4), 32'h01234567);
    req_a(1'b0, SZ_H, 1'b1, 32'(4*DEPTH-2), 32'h0);
    req_a(1'b1, SZ_H, 1'b0, 32'(4*DEPTH-4), 32'h0000C3C3);
    req_a(1'b0, SZ_W, 1'b0, 32'(4*DEPTH-4), 32'h0);

    // Reset during WAIT (landing on the commit edge) aborts the store.
    req_a(1'b1, SZ_W, 1'b0, 32'h20, 32'h0);
    drive_a('{we: 1'b1, size: SZ_W, uns: 1'b0, addr: 32'h20, wdata: 32'h12345678});
    check("abort_ready", {31'h0, ready_a}, 32'd1);
    @(negedge clk);
    valid_a = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", {31'h0, ready_a}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'h0, ready_a}, 32'd1);
    check("abort_no_rsp", {31'h0, rsp_valid_a}, 32'd0);
    req_a(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);

    // Back-to-back on dut_b with req_valid held high.
    b_seq[0] = '{we: 1'b1, size: SZ_W, uns: 1'b0, addr: 32'h40, wdata: 32'hCAFEF00D};
    b_seq[1] = '{we: 1'b0, size: SZ_W, uns: 1'b0, addr: 32'h40, wdata: 32'h0};
    b_seq[2] = '{we: 1'b1, size: SZ_H, uns: 1'b0, addr: 32'h42, wdata: 32'h0000BEEF};
    b_seq[3] = '{we: 1'b0, size: SZ_W, uns: 1'b0, addr: 32'h40, wdata: 32'h0};
    b_seq[4] = '{we: 1'b0, size: SZ_B, uns: 1'b0, addr: 32'h43, wdata: 32'h0};
    last_hs = 0;
    for (int i = 0; i < 5; i++) begin
      valid_b = 1'b1;
      we_b    = b_seq[i].we;
      size_b  = b_seq[i].size;
      uns_b   = b_seq[i].uns;
      addr_b  = b_seq[i].addr;
      wdata_b = b_seq[i].wdata;
      wt = 0;
      while (!ready_b && wt < 10) begin
        @(negedge clk);
        wt++;
      end
      if (!ready_b) begin
        check("b_ready_timeout", 32'd0, 32'd1);
        break;
      end
      model(1'b1, b_seq[i], rd_b, er_b);
      q_b.push_back('{rdata: rd_b, err: er_b, t: cyc});
      if (i > 0) check("b_spacing", cyc - last_hs, 32'd2);
      last_hs = cyc;
      @(negedge clk);
      check("b_ready_in_resp", {31'h0, ready_b}, 32'd0);
    end
    valid_b = 1'b0;

    repeat (5) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
